fc_mac_stage: RTL

Sequential fully-connected compute stage that sits directly downstream of a neuron layer register bank. It reads the layer's parallel `values` vector, streams in a bias plus one weight per input neuron for every output neuron, and accumulates in signed fixed point. It writes each finished output neuron into the next layer's register bank through that bank's `load_en`/`load_value`/`load_address` port. The design uses one MAC, one output neuron at a time, and a valid/ready weight stream.

---
 rtl/fc_mac_stage.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fc_mac_stage.sv
// ---------------------------------------------------------------------------
// fc_mac_stage
//
// Purpose:
//   Sequential fully-connected compute stage. For every destination neuron it
//   takes a bias word followed by one weight per source neuron from a
//   valid/ready stream. It accumulates bias + sum(values[i] * weight[i]) in
//   signed fixed point on a single MAC. It then writes the rescaled,
//   saturated result into the destination layer's register bank.
//
// Configuration macro:
//   FC_MAC_RELU_EN - when defined, negative saturated results are written as 0.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high
//   start         in   one-cycle request to compute the whole destination layer
//   values        in   source layer neuron values, held stable while busy
//   weight_valid  in   weight word is valid
//   weight        in   stream word: bias, then weights for inputs 0..IN_SZ-1
//   weight_ready  out  stage accepts a weight word this cycle
//   load_en       out  one-cycle write strobe to the destination layer
//   load_value    out  result neuron value
//   load_address  out  destination neuron index, zero-extended
//   busy          out  layer computation in progress (through the done cycle)
//   done          out  one-cycle pulse when the layer is complete
// ---------------------------------------------------------------------------
module fc_mac_stage #(
    parameter int SIZE   = 16,
    parameter int FRAC   = 8,
    parameter int IN_SZ  = 4,
    parameter int OUT_SZ = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [0:IN_SZ-1][SIZE-1:0]    values,
    input  logic                          weight_valid,
    input  logic [SIZE-1:0]               weight,
    output logic                          weight_ready,
    output logic                          load_en,
    output logic [SIZE-1:0]               load_value,
    output logic [SIZE-1:0]               load_address,
    output logic                          busy,
    output logic                          done
);

    // Accumulator is wide enough for IN_SZ full products plus the bias, so
    // no intermediate overflow can happen before the final saturation.
    localparam int ACC_W = 2 * SIZE + $clog2(IN_SZ + 1);
    localparam int IW    = (IN_SZ  > 1) ? $clog2(IN_SZ)  : 1;
    localparam int OW    = (OUT_SZ > 1) ? $clog2(OUT_SZ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IW-1:0]             inIdx_q, inIdx_d;
    logic [OW-1:0]             outIdx_q, outIdx_d;

    logic                      handshake;
    logic [SIZE-1:0]           selValue;
    logic signed [2*SIZE-1:0]  opValue, opWeight, product;
    logic signed [ACC_W-1:0]   productExt, biasExt, shifted;
    logic [ACC_W-SIZE:0]       upperBits;
    logic                      posOverflow, negOverflow;
    logic [SIZE-1:0]           saturated, result;

    // Multiply-accumulate datapath. Both operands are sign-extended to the
    // full product width, so the low 2*SIZE bits of the product are the exact
    // signed product. The bias is aligned to the product's 2*FRAC scaling.
    always_comb begin
        selValue   = values[inIdx_q];
        opValue    = {{SIZE{selValue[SIZE-1]}}, selValue};
        opWeight   = {{SIZE{weight[SIZE-1]}}, weight};
        product    = opValue * opWeight;
        productExt = {{(ACC_W-2*SIZE){product[2*SIZE-1]}}, product};
        biasExt    = {{(ACC_W-SIZE-FRAC){weight[SIZE-1]}}, weight, {FRAC{1'b0}}};
    end

    // Result path: rescale the accumulator back to FRAC fractional bits with
    // an arithmetic shift (rounds toward minus infinity). Then clamp to the
    // signed SIZE range. Overflow is present when the bits above the result's
    // sign bit do not all match it.
    always_comb begin
        shifted     = acc_q >>> FRAC;
        upperBits   = shifted[ACC_W-1:SIZE-1];
        posOverflow = !shifted[ACC_W-1] && (|upperBits);
        negOverflow =  shifted[ACC_W-1] && !(&upperBits);
        if (posOverflow) begin
            saturated = {1'b0, {(SIZE-1){1'b1}}};
        end else if (negOverflow) begin
            saturated = {1'b1, {(SIZE-1){1'b0}}};
        end else begin
            saturated = shifted[SIZE-1:0];
        end
`ifdef FC_MAC_RELU_EN
        result = saturated[SIZE-1] ? '0 : saturated;
`else
        result = saturated;
`endif
    end

    // State and datapath registers. Reset returns to idle from anywhere and
    // clears the accumulator and both indices.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            inIdx_q  <= '0;
            outIdx_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            inIdx_q  <= inIdx_d;
            outIdx_q <= outIdx_d;
        end
    end

    // Next-state logic. Without a handshake, the BIAS and MAC states hold
    // everything, so stall cycles only shift later events in time.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        inIdx_d  = inIdx_q;
        outIdx_d = outIdx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BIAS;
                    inIdx_d  = '0;
                    outIdx_d = '0;
                end
            end
            S_BIAS: begin
                if (handshake) begin
                    acc_d   = biasExt;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (handshake) begin
                    acc_d = acc_q + productExt;
                    if (inIdx_q == IW'(IN_SZ - 1)) begin
                        inIdx_d = '0;
                        state_d = S_WRITE;
                    end else begin
                        inIdx_d = inIdx_q + IW'(1);
                    end
                end
            end
            S_WRITE: begin
                if (outIdx_q == OW'(OUT_SZ - 1)) begin
                    state_d = S_DONE;
                end else begin
                    outIdx_d = outIdx_q + OW'(1);
                    state_d  = S_BIAS;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only. weight_ready does not
    // depend on weight_valid. The write bus is zeroed outside WRITE.
    always_comb begin
        weight_ready = (state_q == S_BIAS) || (state_q == S_MAC);
        handshake    = weight_valid && weight_ready;
        load_en      = (state_q == S_WRITE);
        load_value   = load_en ? result : '0;
        load_address = load_en ? {{(SIZE-OW){1'b0}}, outIdx_q} : '0;
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
    end

endmodule
